// File: rtl/instruction_sequencer.sv
// Instruction sequencer: issues program words on iin for HOLD_CYCLES each and captures bus values in a FIFO.
// Optional macro SEQ_LOOP_EN adds a stop input; runs then loop over the program until stop is seen.
module instruction_sequencer #(
  parameter int AW          = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_AW     = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
`ifdef SEQ_LOOP_EN
  input  logic          stop,
`endif
  output logic [15:0]   iin,
  output logic          busy,
  output logic          done,
  input  logic [15:0]   bus_in,
  input  logic          bus_valid,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overflow
);

  localparam int DEPTH  = 2 ** AW;
  localparam int FDEPTH = 2 ** FIFO_AW;
  localparam int CW     = 5;
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [AW:0]         len_q, len_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         iin_q, iin_d;
  logic                overflow_q, overflow_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic                stop_seen_q, stop_seen_d;

  logic [15:0] prog_mem [DEPTH];
  logic [15:0] fifo_mem [FDEPTH];

  logic          mem_we, run_start, last_word, finish_now;
  logic [AW-1:0] pc_next;
  logic [15:0]   word0;
  logic          push, pop, full, do_push;

  assign mem_we    = (state_q == IDLE) && load_en;
  assign run_start = (state_q == IDLE) && start && (prog_len != '0);
  assign pc_next   = pc_q + AW'(1);
  assign last_word = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  // A same-cycle load to address 0 must be visible as the first issued word.
  assign word0     = (mem_we && (load_addr == '0)) ? load_data : prog_mem[0];

`ifdef SEQ_LOOP_EN
  assign finish_now = stop_seen_q;
`else
  assign finish_now = last_word;
  assign stop_seen_d = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (mem_we) prog_mem[load_addr] <= load_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (prog_len != '0) ? RUN : DONE;
      RUN:     if ((cnt_q == '0) && finish_now) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    pc_d  = pc_q;
    len_d = len_q;
    cnt_d = cnt_q;
    iin_d = iin_q;
    if (run_start) begin
      len_d = prog_len;
      pc_d  = '0;
      iin_d = word0;
      cnt_d = HOLD_RELOAD;
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (finish_now) begin
        iin_d = '0;
      end else if (last_word) begin
        pc_d  = '0;
        iin_d = prog_mem[0];
        cnt_d = HOLD_RELOAD;
      end else begin
        pc_d  = pc_next;
        iin_d = prog_mem[pc_next];
        cnt_d = HOLD_RELOAD;
      end
    end
  end

`ifdef SEQ_LOOP_EN
  always_comb begin
    stop_seen_d = stop_seen_q;
    if (state_q == RUN && stop) stop_seen_d = 1'b1;
    if (state_q == DONE)        stop_seen_d = 1'b0;
  end
`endif

  // Capture FIFO: a full FIFO still accepts a push when the head leaves in the same cycle.
  assign push    = bus_valid;
  assign pop     = out_valid && out_ready;
  assign full    = (count_q == (FIFO_AW+1)'(FDEPTH));
  assign do_push = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (run_start)              overflow_d = 1'b0;
    if (push && full && !pop)   overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (do_push) fifo_mem[wr_ptr_q] <= bus_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      iin_q       <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stop_seen_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      iin_q       <= iin_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign iin       = iin_q;
  assign overflow  = overflow_q;
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : 16'h0000;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer (default build, SEQ_LOOP_EN undefined).
// Expected iin/busy/done traces and FIFO contents are queued when stimulus is driven.
module tb_instruction_sequencer;

  localparam int AW = 4;
  localparam int HOLD = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic [15:0]   iin;
  logic          busy, done;
  logic [15:0]   bus_in = '0;
  logic          bus_valid = 1'b0;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_iin[$];
  logic        exp_busy[$];
  logic        exp_done[$];
  logic [15:0] exp_fifo[$];
  logic [15:0] prog_words[16];

  instruction_sequencer #(.AW(AW), .HOLD_CYCLES(HOLD), .FIFO_AW(3)) dut (
    .clock(clock), .resetn(resetn), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .prog_len(prog_len), .iin(iin),
    .busy(busy), .done(done), .bus_in(bus_in), .bus_valid(bus_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Queue the per-cycle trace of a run of n words from prog_words, followed by DONE and IDLE.
  task automatic queue_run(input int n);
    for (int w = 0; w < n; w++)
      for (int h = 0; h < HOLD; h++) begin
        exp_iin.push_back(prog_words[w]); exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
      end
    exp_iin.push_back(16'h0); exp_busy.push_back(1'b0); exp_done.push_back(1'b1);
    exp_iin.push_back(16'h0); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (iin !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
          overflow !== 1'b0 || out_data !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_state[%0d]: got iin=%h busy=%b done=%b ov=%b ovf=%b od=%h expected all zero",
                 k, iin, busy, done, out_valid, overflow, out_data);
      end
      resetn = 1'b1;
      tick();
    end
  endtask

  task automatic test_basic_run();
    prog_words[0] = 16'h1111; prog_words[1] = 16'h2222; prog_words[2] = 16'h3333;
    for (int i = 0; i < 3; i++) load_word(AW'(i), prog_words[i]);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy); end
    queue_run(3);
    start = 1'b1; prog_len = 5'd3;
    tick();
    start = 1'b0;
    for (int c = 0; exp_iin.size() > 0; c++) begin
      logic [15:0] ei; logic eb, ed;
      ei = exp_iin.pop_front(); eb = exp_busy.pop_front(); ed = exp_done.pop_front();
      checks++;
      if (iin !== ei || busy !== eb || done !== ed) begin
        errors++;
        $display("[TB] FAIL basic_run cycle %0d: got iin=%h busy=%b done=%b expected iin=%h busy=%b done=%b",
                 c, iin, busy, done, ei, eb, ed);
      end
      tick();
    end
  endtask

  task automatic test_len_zero();
    start = 1'b1; prog_len = 5'd0;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || iin !== 16'h0) begin
      errors++;
      $display("[TB] FAIL len_zero_done: got done=%b busy=%b iin=%h expected 1 0 0000", done, busy, iin);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || iin !== 16'h0) begin
      errors++;
      $display("[TB] FAIL len_zero_after: got done=%b busy=%b iin=%h expected 0 0 0000", done, busy, iin);
    end
  endtask

  task automatic test_ignore_in_run();
    queue_run(3);
    start = 1'b1; prog_len = 5'd3;
    tick();
    start = 1'b0;
    for (int c = 0; exp_iin.size() > 0; c++) begin
      logic [15:0] ei; logic eb, ed;
      ei = exp_iin.pop_front(); eb = exp_busy.pop_front(); ed = exp_done.pop_front();
      checks++;
      if (iin !== ei || busy !== eb || done !== ed) begin
        errors++;
        $display("[TB] FAIL ignore_in_run cycle %0d: got iin=%h busy=%b done=%b expected iin=%h busy=%b done=%b",
                 c, iin, busy, done, ei, eb, ed);
      end
      if (c == 2) begin
        load_en = 1'b1; load_addr = 4'd1; load_data = 16'hBEEF; start = 1'b1; prog_len = 5'd1;
      end else begin
        load_en = 1'b0; start = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_full_length();
    for (int i = 0; i < 16; i++) begin
      prog_words[i] = 16'hC000 + 16'(i * 16'h0111);
      load_word(AW'(i), prog_words[i]);
    end
    queue_run(16);
    start = 1'b1; prog_len = 5'd16;
    tick();
    start = 1'b0;
    for (int c = 0; exp_iin.size() > 0; c++) begin
      logic [15:0] ei; logic eb, ed;
      ei = exp_iin.pop_front(); eb = exp_busy.pop_front(); ed = exp_done.pop_front();
      checks++;
      if (iin !== ei || busy !== eb || done !== ed) begin
        errors++;
        $display("[TB] FAIL full_length cycle %0d: got iin=%h busy=%b done=%b expected iin=%h busy=%b done=%b",
                 c, iin, busy, done, ei, eb, ed);
      end
      tick();
    end
  endtask

  task automatic test_fifo_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      bus_valid = 1'b1; bus_in = 16'(i);
      if (i <= 8) exp_fifo.push_back(16'(i));
      tick();
    end
    bus_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fifo_overflow_flags: got out_valid=%b overflow=%b expected 1 1", out_valid, overflow);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_fifo.size() > 0; c++) begin
      logic [15:0] e;
      e = exp_fifo.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        errors++;
        $display("[TB] FAIL fifo_overflow_pop: got valid=%b data=%h expected 1 %h", out_valid, out_data, e);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (exp_fifo.size() != 0 || out_valid !== 1'b0 || out_data !== 16'h0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fifo_overflow_end: got left=%0d valid=%b data=%h overflow=%b expected 0 0 0000 1",
               exp_fifo.size(), out_valid, out_data, overflow);
      exp_fifo.delete();
    end
  endtask

  task automatic test_full_push_pop();
    start = 1'b1; prog_len = 5'd1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL start_clears_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      bus_valid = 1'b1; bus_in = 16'h0010 + 16'(i);
      exp_fifo.push_back(bus_in);
      tick();
    end
    bus_valid = 1'b1; bus_in = 16'hAAAA; out_ready = 1'b1;
    begin
      logic [15:0] e;
      e = exp_fifo.pop_front();
      checks++;
      if (out_data !== e) begin errors++; $display("[TB] FAIL full_pp_head: got %h expected %h", out_data, e); end
    end
    exp_fifo.push_back(16'hAAAA);
    tick();
    bus_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_pp_flags: got overflow=%b out_valid=%b expected 0 1", overflow, out_valid);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_fifo.size() > 0; c++) begin
      logic [15:0] e;
      e = exp_fifo.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        errors++;
        $display("[TB] FAIL full_pp_drain: got valid=%b data=%h expected 1 %h", out_valid, out_data, e);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_pp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    prog_words[0] = 16'h1111; prog_words[1] = 16'h2222; prog_words[2] = 16'h3333;
    for (int i = 0; i < 3; i++) load_word(AW'(i), prog_words[i]);
    for (int i = 0; i < 2; i++) begin
      bus_valid = 1'b1; bus_in = 16'h7700 + 16'(i);
      tick();
    end
    bus_valid = 1'b0;
    start = 1'b1; prog_len = 5'd3;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (iin !== 16'h2222) begin errors++; $display("[TB] FAIL mid_run_precond: got %h expected 2222", iin); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (iin !== 16'h0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got iin=%h busy=%b out_valid=%b expected 0000 0 0", iin, busy, out_valid);
    end
    @(negedge clock);
    resetn = 1'b1;
    tick();
    start = 1'b1; prog_len = 5'd3;
    tick();
    start = 1'b0;
    checks++;
    if (iin !== 16'h1111 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL replay_first: got iin=%h busy=%b expected 1111 1", iin, busy);
    end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 1 || iin !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL replay_end: got pulses=%0d iin=%h busy=%b expected 1 0000 0", pulses, iin, busy);
    end
  endtask

  task automatic test_load_start_same_cycle();
    prog_words[0] = 16'h5A5A;
    queue_run(1);
    load_en = 1'b1; load_addr = 4'd0; load_data = 16'h5A5A;
    start = 1'b1; prog_len = 5'd1;
    tick();
    load_en = 1'b0; start = 1'b0;
    for (int c = 0; exp_iin.size() > 0; c++) begin
      logic [15:0] ei; logic eb, ed;
      ei = exp_iin.pop_front(); eb = exp_busy.pop_front(); ed = exp_done.pop_front();
      checks++;
      if (iin !== ei || busy !== eb || done !== ed) begin
        errors++;
        $display("[TB] FAIL load_start cycle %0d: got iin=%h busy=%b done=%b expected iin=%h busy=%b done=%b",
                 c, iin, busy, done, ei, eb, ed);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_len_zero();
    test_ignore_in_run();
    test_full_length();
    test_fifo_overflow();
    test_full_push_pop();
    test_reset_mid_run();
    test_load_start_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
